// File: rtl/vtg_pkg.sv
// Shared types and mode table for the video timing generator.
// Optional frame counter in video_timing_gen: VTG_FRAME_CNT_EN.
package vtg_pkg;

  typedef logic [1:0] vtg_mode_t;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_fp;
    logic [11:0] h_bp;
    logic [11:0] h_sync;
    logic [11:0] h_act;
    logic [11:0] v_total;
    logic [11:0] v_fp;
    logic [11:0] v_bp;
    logic [11:0] v_sync;
    logic [11:0] v_act;
  } vtg_timing_t;

  localparam vtg_mode_t IDX_1080P = 2'd0;
  localparam vtg_mode_t IDX_1600P = 2'd1;
  localparam vtg_mode_t IDX_720P  = 2'd2;
  localparam vtg_mode_t IDX_480P  = 2'd3;

  localparam vtg_timing_t MODE_1080P = '{
    h_total: 12'd2200, h_fp: 12'd88,
    h_bp:    12'd148,  h_sync: 12'd44,
    h_act:   12'd1920,
    v_total: 12'd1125, v_fp: 12'd4,
    v_bp:    12'd36,   v_sync: 12'd5,
    v_act:   12'd1080
  };

  localparam vtg_timing_t MODE_1600P = '{
    h_total: 12'd2720, h_fp: 12'd48,
    h_bp:    12'd80,   h_sync: 12'd32,
    h_act:   12'd2560,
    v_total: 12'd1646, v_fp: 12'd3,
    v_bp:    12'd37,   v_sync: 12'd6,
    v_act:   12'd1600
  };

  localparam vtg_timing_t MODE_720P = '{
    h_total: 12'd1650, h_fp: 12'd110,
    h_bp:    12'd220,  h_sync: 12'd40,
    h_act:   12'd1280,
    v_total: 12'd750,  v_fp: 12'd5,
    v_bp:    12'd20,   v_sync: 12'd5,
    v_act:   12'd720
  };

  localparam vtg_timing_t MODE_480P = '{
    h_total: 12'd800,  h_fp: 12'd16,
    h_bp:    12'd48,   h_sync: 12'd96,
    h_act:   12'd640,
    v_total: 12'd525,  v_fp: 12'd10,
    v_bp:    12'd33,   v_sync: 12'd2,
    v_act:   12'd480
  };

endpackage

// File: rtl/vtg_mode_rom.sv
// Combinational mode index to timing-entry lookup.
// Part of video_timing_gen (VTG_FRAME_CNT_EN has no effect here).
module vtg_mode_rom
  import vtg_pkg::*;
(
  input  vtg_mode_t   i_mode,
  output vtg_timing_t o_timing
);

  always_comb begin
    o_timing = MODE_1080P;
    unique case (1'b1)
      (i_mode == IDX_1080P): o_timing = MODE_1080P;
      (i_mode == IDX_1600P): o_timing = MODE_1600P;
      (i_mode == IDX_720P):  o_timing = MODE_720P;
      (i_mode == IDX_480P):  o_timing = MODE_480P;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-switchable hs/vs/de timing generator, mode change at frame end.
// Define VTG_FRAME_CNT_EN to add the frame_cnt output.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int          X_BITS       = 12,
  parameter int          Y_BITS       = 12,
  parameter logic [1:0]  DEFAULT_MODE = 2'd0
)(
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              mode_req,
  input  logic [1:0]        mode_sel,
  output logic [1:0]        mode_cur,
  output logic              mode_ack,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [X_BITS-1:0] act_x,
  output logic [Y_BITS-1:0] act_y,
  output logic              frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  vtg_timing_t       w_t;
  vtg_mode_t         r_mode;
  vtg_mode_t         r_pend_mode;
  logic              r_pend;
  logic [X_BITS-1:0] r_h_cnt;
  logic [Y_BITS-1:0] r_v_cnt;

  logic              r_ack;
  logic              r_hs;
  logic              r_vs;
  logic              r_de;
  logic              r_fs;
  logic [X_BITS-1:0] r_ax;
  logic [Y_BITS-1:0] r_ay;

  vtg_mode_rom u_rom (
    .i_mode   (r_mode),
    .o_timing (w_t)
  );

  logic [X_BITS-1:0] w_h_last;
  logic [X_BITS-1:0] w_h_beg;
  logic [X_BITS-1:0] w_h_end;
  logic [Y_BITS-1:0] w_v_last;
  logic [Y_BITS-1:0] w_v_beg;
  logic [Y_BITS-1:0] w_v_end;
  logic              w_unused;

  assign w_h_last = X_BITS'(w_t.h_total) - X_BITS'(1);
  assign w_h_beg  = X_BITS'(w_t.h_sync) + X_BITS'(w_t.h_bp);
  assign w_h_end  = w_h_beg + X_BITS'(w_t.h_act);
  assign w_v_last = Y_BITS'(w_t.v_total) - Y_BITS'(1);
  assign w_v_beg  = Y_BITS'(w_t.v_sync) + Y_BITS'(w_t.v_bp);
  assign w_v_end  = w_v_beg + Y_BITS'(w_t.v_act);
  // Porches are implied by the other fields.
  assign w_unused = ^{w_t.h_fp, w_t.v_fp};

  logic      w_h_wrap;
  logic      w_v_wrap;
  logic      w_apply;
  vtg_mode_t w_next_mode;

  assign w_h_wrap    = (r_h_cnt == w_h_last);
  assign w_v_wrap    = (r_v_cnt == w_v_last);
  assign w_apply     = w_h_wrap & w_v_wrap
                     & (r_pend | mode_req);
  assign w_next_mode = mode_req ? mode_sel : r_pend_mode;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + Y_BITS'(1);
    end else begin
      r_h_cnt <= r_h_cnt + X_BITS'(1);
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_mode      <= DEFAULT_MODE;
      r_pend_mode <= DEFAULT_MODE;
      r_pend      <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_mode <= w_next_mode;
        r_pend <= 1'b0;
      end else if (mode_req) begin
        r_pend_mode <= mode_sel;
        r_pend      <= 1'b1;
      end
    end
  end

  logic              w_hs;
  logic              w_vs;
  logic              w_de;
  logic              w_fs;
  logic [X_BITS-1:0] w_ax;
  logic [Y_BITS-1:0] w_ay;

  assign w_hs = (r_h_cnt < X_BITS'(w_t.h_sync));
  assign w_vs = (r_v_cnt < Y_BITS'(w_t.v_sync));
  assign w_de = (r_h_cnt >= w_h_beg) & (r_h_cnt < w_h_end)
              & (r_v_cnt >= w_v_beg) & (r_v_cnt < w_v_end);
  assign w_fs = (r_h_cnt == '0) & (r_v_cnt == '0);
  assign w_ax = w_de ? r_h_cnt - w_h_beg : '0;
  assign w_ay = w_de ? r_v_cnt - w_v_beg : '0;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_de <= 1'b0;
      r_fs <= 1'b0;
      r_ax <= '0;
      r_ay <= '0;
    end else begin
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_de <= w_de;
      r_fs <= w_fs;
      r_ax <= w_ax;
      r_ay <= w_ay;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_cnt <= '0;
    end else if (w_apply) begin
      r_frame_cnt <= '0;
    end else if (w_h_wrap & w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign mode_cur    = r_mode;
  assign mode_ack    = r_ack;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign act_x       = r_ax;
  assign act_y       = r_ay;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: arithmetic frame model plus directed cases.
// Honours VTG_FRAME_CNT_EN when the design is built with it.
`timescale 1ns/1ps
module tb_video_timing_gen;

  logic        pix_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic [1:0]  mode_cur;
  logic        mode_ack;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] act_x;
  logic [11:0] act_y;
  logic        frame_start;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  video_timing_gen #(
    .X_BITS       (12),
    .Y_BITS       (12),
    .DEFAULT_MODE (2'd0)
  ) dut (
    .pix_clk     (pix_clk),
    .rstn        (rstn),
    .mode_req    (mode_req),
    .mode_sel    (mode_sel),
    .mode_cur    (mode_cur),
    .mode_ack    (mode_ack),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .act_x       (act_x),
    .act_y       (act_y),
    .frame_start (frame_start)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 pix_clk = ~pix_clk;

  int HT [4] = '{2200, 2720, 1650, 800};
  int HS [4] = '{44, 32, 40, 96};
  int HB [4] = '{148, 80, 220, 48};
  int HA [4] = '{1920, 2560, 1280, 640};
  int VT [4] = '{1125, 1646, 750, 525};
  int VS [4] = '{5, 6, 5, 2};
  int VB [4] = '{36, 37, 20, 33};
  int VA [4] = '{1080, 1600, 720, 480};

  int n_chk = 0;
  int n_pass = 0;

  // model state: pixel index within frame, mode, pending request
  int p, m, pend, pm, fcnt;
  logic [30:0] e_bus;

  logic [11:0] j_hv;
  logic [11:0] j_vv;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [30:0] dut_bus();
    return {mode_ack, mode_cur, hs, vs, de, frame_start,
            act_x, act_y};
  endfunction

  task automatic model_reset();
    p = 0; m = 0; pend = 0; pm = 0; fcnt = 0;
  endtask

  task automatic model_step();
    int ht, vt, h, v, hb, vb;
    logic e_hs, e_vs, e_de, e_fs, e_ack;
    logic [11:0] e_x, e_y;
    ht = HT[m]; vt = VT[m];
    h = p % ht; v = p / ht;
    hb = HS[m] + HB[m]; vb = VS[m] + VB[m];
    e_hs = (h < HS[m]);
    e_vs = (v < VS[m]);
    e_de = (h >= hb) && (h < hb + HA[m])
        && (v >= vb) && (v < vb + VA[m]);
    e_x = e_de ? 12'(h - hb) : 12'd0;
    e_y = e_de ? 12'(v - vb) : 12'd0;
    e_fs = (p == 0);
    e_ack = 1'b0;
    if (p == ht * vt - 1 && (pend != 0 || mode_req)) begin
      m = mode_req ? int'(mode_sel) : pm;
      pend = 0; p = 0; fcnt = 0; e_ack = 1'b1;
    end else begin
      p++;
      if (p == ht * vt) begin
        p = 0;
        fcnt = (fcnt + 1) % 65536;
      end
      if (mode_req) begin
        pend = 1; pm = int'(mode_sel);
      end
    end
    e_bus = {e_ack, 2'(m), e_hs, e_vs, e_de, e_fs, e_x, e_y};
  endtask

  task automatic tick(bit req, logic [1:0] sel);
    mode_req = req;
    mode_sel = sel;
    @(posedge pix_clk);
    model_step();
    @(negedge pix_clk);
    mode_req = 1'b0;
    check("cyc", 64'(dut_bus()), 64'(e_bus));
`ifdef VTG_FRAME_CNT_EN
    check("frame_cnt", 64'(frame_cnt), 64'(fcnt));
`endif
  endtask

  // Move the counters to an arbitrary frame position (bench shortcut).
  task automatic jump(int h, int v);
    j_hv = 12'(h);
    j_vv = 12'(v);
    force dut.r_h_cnt = j_hv;
    force dut.r_v_cnt = j_vv;
    #1;
    release dut.r_h_cnt;
    release dut.r_v_cnt;
    p = v * HT[m] + h;
  endtask

  int cnt, pos, acks;
  bit found;

  task automatic line_len(string tag, int exp_len);
    int t0, t1;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 6000 && t1 < 0; i++) begin
      logic prev;
      prev = hs;
      tick(0, 2'd0);
      if (hs && !prev) begin
        if (t0 < 0) t0 = i;
        else t1 = i;
      end
    end
    check(tag, 64'(t1 - t0), 64'(exp_len));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge pix_clk);
    check("rst_out", 64'(dut_bus()), 64'd0);
    rstn = 1'b1;

    tick(0, 2'd0);
    check("first_edge", 64'({hs, vs, frame_start}), 64'd7);
    cnt = int'(hs);
    for (int i = 1; i < 2200; i++) begin
      tick(0, 2'd0);
      cnt += int'(hs);
    end
    check("hs_per_line", 64'(cnt), 64'd44);

    jump(150, 40);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(0, 2'd0);
      cnt += int'(de);
    end
    check("de_line40", 64'(cnt), 64'd0);

    jump(180, 41);
    pos = -1;
    for (int i = 1; i <= 40 && pos < 0; i++) begin
      tick(0, 2'd0);
      if (de) begin
        pos = i;
        check("first_de_x", 64'(act_x), 64'd0);
        check("first_de_y", 64'(act_y), 64'd0);
      end
    end
    check("first_de_col", 64'(pos), 64'd13);

    jump(1000, 500);
    tick(1, 2'd1);
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      tick(0, 2'd0);
      acks += int'(mode_ack);
    end
    check("no_early_ack", 64'({acks[7:0], mode_cur}), 64'd0);
    jump(2150, 1124);
    pos = -1;
    for (int i = 1; i <= 200; i++) begin
      tick(0, 2'd0);
      if (mode_ack) begin
        acks++;
        if (pos < 0) begin
          pos = i;
          check("ack_mode", 64'(mode_cur), 64'd1);
        end
      end
    end
    check("ack_pos", 64'(pos), 64'd50);
    check("ack_once", 64'(acks), 64'd1);
    line_len("len_1600p", 2720);
    jump(100, 1642);
    cnt = 0;
    for (int i = 0; i < 2820; i++) begin
      tick(0, 2'd0);
      cnt += int'(de);
    end
    check("last_active_line", 64'(cnt), 64'd2560);

    jump(0, 200);
    tick(1, 2'd2);
    repeat (20) tick(0, 2'd0);
    tick(1, 2'd3);
    jump(2700, 1645);
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      tick(0, 2'd0);
      acks += int'(mode_ack);
    end
    check("two_req_acks", 64'(acks), 64'd1);
    check("two_req_mode", 64'(mode_cur), 64'd3);
    line_len("len_480p", 800);

    jump(790, 524);
    repeat (9) tick(0, 2'd0);
    tick(1, 2'd2);
    check("fe_req", 64'({mode_ack, mode_cur}), 64'h6);

    tick(1, 2'd3);
    jump(1640, 749);
    repeat (30) tick(0, 2'd0);
    check("back_to_480p", 64'(mode_cur), 64'd3);
    jump(300, 100);
    tick(1, 2'd2);
    repeat (5) tick(0, 2'd0);
    #2 rstn = 1'b0;
    #1 check("async_rst", 64'(dut_bus()), 64'd0);
    model_reset();
    repeat (2) @(negedge pix_clk);
    rstn = 1'b1;
    tick(0, 2'd0);
    jump(2190, 1124);
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      tick(0, 2'd0);
      acks += int'(mode_ack);
    end
    check("no_ack_after_rst", 64'({acks[7:0], mode_cur}), 64'd0);

    for (int it = 0; it < 30; it++) begin
      int n;
      if ($urandom_range(0, 2) != 0)
        jump(HT[m] - 1 - int'($urandom_range(0, 150)),
             VT[m] - 1);
      else
        jump(int'($urandom_range(0, HT[m] - 1)),
             int'($urandom_range(0, VT[m] - 1)));
      n = int'($urandom_range(20, 300));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 39) == 0)
          tick(1, 2'($urandom_range(0, 3)));
        else
          tick(0, 2'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
